data_mem_arbiter: RTL and testbench

// - Shares one data_mem instance between two requesters: port 0 (core LSU) and port 1 (DMA/debug).
// - Arbitration and grant are combinational, in the same cycle as the request. Each read response is routed back to the port that issued it.
// - Keeps data_mem semantics on every port: read data is valid the cycle after the grant and held stable until that port's next granted read.
//

---
 rtl/data_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single data_mem: same-cycle grant, per-port read routing and hold.
// Build option DMEM_ARB_RR_EN selects round-robin; when undefined, port 0 has priority with a burst-limited starvation guard.
module data_mem_arbiter #(
    parameter int MAX_BURST = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_ready_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_rvalid_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_ready_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_rvalid_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    // Handshake: a requester raises mN_req_i with its payload and holds all of it until
    // mN_ready_o is high in the same cycle; that cycle is the transfer. mN_rvalid_o is a
    // one-cycle pulse one cycle after a read transfer and cannot be back-pressured.

    logic gnt0;
    logic gnt1;
    logic pick1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_i && mem_ready_i) begin
            if (m0_req_i && m1_req_i) begin
                gnt1 = pick1;
                gnt0 = !pick1;
            end else begin
                gnt0 = m0_req_i;
                gnt1 = m1_req_i;
            end
        end
    end

    assign m0_ready_o = gnt0;
    assign m1_ready_o = gnt1;

`ifdef DMEM_ARB_RR_EN
    // Pointer resets to port 1 so port 0 wins the first contention.
    logic last_q;
    logic unused_max_burst;

    assign unused_max_burst = |MAX_BURST[7:0];
    assign pick1 = !last_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= 1'b1;
        end else if (gnt0 || gnt1) begin
            last_q <= gnt1;
        end
    end
`else
    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    // Counts port-0 grants taken while port 1 is waiting; at the limit port 1 gets one slot.
    logic [7:0] burst_q;

    assign pick1 = (burst_q == MAX_BURST_C);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            burst_q <= 8'd0;
        end else if (gnt1 || !m1_req_i) begin
            burst_q <= 8'd0;
        end else if (gnt0 && burst_q != 8'hFF) begin
            burst_q <= burst_q + 8'd1;
        end
    end
`endif

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b0000;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        if (gnt0) begin
            mem_we_o    = m0_we_i;
            mem_be_o    = m0_be_i;
            mem_addr_o  = m0_addr_i;
            mem_wdata_o = m0_wdata_i;
        end else if (gnt1) begin
            mem_we_o    = m1_we_i;
            mem_be_o    = m1_be_i;
            mem_addr_o  = m1_addr_i;
            mem_wdata_o = m1_wdata_i;
        end
    end

    assign mem_req_o = gnt0 || gnt1;

    // Read response tracking: one outstanding read at most, owned by pend_port_q.
    logic        pend_vld_q;
    logic        pend_port_q;
    logic [31:0] rdata_hold_0;
    logic [31:0] rdata_hold_1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_vld_q   <= 1'b0;
            pend_port_q  <= 1'b0;
            rdata_hold_0 <= 32'd0;
            rdata_hold_1 <= 32'd0;
        end else begin
            pend_vld_q  <= mem_req_o && !mem_we_o;
            pend_port_q <= gnt1;
            if (m0_rvalid_o) begin
                rdata_hold_0 <= mem_rdata_i;
            end
            if (m1_rvalid_o) begin
                rdata_hold_1 <= mem_rdata_i;
            end
        end
    end

    assign m0_rvalid_o = pend_vld_q && !pend_port_q;
    assign m1_rvalid_o = pend_vld_q && pend_port_q;
    assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : rdata_hold_0;
    assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : rdata_hold_1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: behavioural data_mem, directed scenarios, then randomized
// contention checked against a rule-level model of grants, memory contents and responses.
module tb_data_mem_arbiter;
    localparam int MAXB = 3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic        m0_ready_o, m0_rvalid_o, m1_ready_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'd0;
    logic        mem_ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    // clock / reset
    always #5 clk_i = ~clk_i;

    data_mem_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_ready_o(m0_ready_o), .m0_rdata_o(m0_rdata_o),
        .m0_rvalid_o(m0_rvalid_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_ready_o(m1_ready_o), .m1_rdata_o(m1_rdata_o),
        .m1_rvalid_o(m1_rvalid_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
    endfunction

    // behavioural data_mem: 64 words, write at the grant edge, read data one cycle later
    logic [31:0] env_mem [64];
    bit env_ready = 1'b0;
    always @(posedge clk_i) begin
        if (!env_ready) begin
            for (int i = 0; i < 64; i++) env_mem[i] = init_word(i);
            env_ready = 1'b1;
        end
        if (mem_req_o && mem_ready_i) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) env_mem[mem_addr_o[7:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= env_mem[mem_addr_o[7:2]];
            end
        end
    end

    // reference model state
    logic [31:0] shd_mem [64];
    logic [32:0] exp_q [$];
    logic [31:0] exp_hold [2];
    logic        mdl_last;
    int          mdl_run;
    logic        obs_g0, obs_g1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void predict(output logic g0, output logic g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst_i && mem_ready_i) begin
            if (m0_req_i && m1_req_i) begin
`ifdef DMEM_ARB_RR_EN
                g1 = (mdl_last == 1'b0);
`else
                g1 = (mdl_run == MAXB);
`endif
                g0 = !g1;
            end else begin
                g0 = m0_req_i;
                g1 = m1_req_i;
            end
        end
    endfunction

    // one cycle: called just after a negedge with inputs driven, returns at the next negedge
    task automatic step();
        logic        e0, e1, ew, rv0, rv1;
        logic [3:0]  ebe;
        logic [31:0] ea, ewd;
        logic [32:0] resp;
        #1;
        rv0 = 1'b0;
        rv1 = 1'b0;
        if (exp_q.size() > 0) begin
            resp = exp_q.pop_front();
            if (resp[32]) begin rv1 = 1'b1; exp_hold[1] = resp[31:0]; end
            else          begin rv0 = 1'b1; exp_hold[0] = resp[31:0]; end
        end
        check("m0_rvalid", 32'(m0_rvalid_o), 32'(rv0));
        check("m1_rvalid", 32'(m1_rvalid_o), 32'(rv1));
        check("m0_rdata", m0_rdata_o, exp_hold[0]);
        check("m1_rdata", m1_rdata_o, exp_hold[1]);

        predict(e0, e1);
        obs_g0 = m0_ready_o;
        obs_g1 = m1_ready_o;
        ew = 1'b0; ebe = 4'd0; ea = 32'd0; ewd = 32'd0;
        if (e0)      begin ew = m0_we_i; ebe = m0_be_i; ea = m0_addr_i; ewd = m0_wdata_i; end
        else if (e1) begin ew = m1_we_i; ebe = m1_be_i; ea = m1_addr_i; ewd = m1_wdata_i; end
        check("m0_ready", 32'(m0_ready_o), 32'(e0));
        check("m1_ready", 32'(m1_ready_o), 32'(e1));
        check("mem_req", 32'(mem_req_o), 32'(e0 | e1));
        check("mem_we", 32'(mem_we_o), 32'(ew));
        check("mem_be", 32'(mem_be_o), 32'(ebe));
        check("mem_addr", mem_addr_o, ea);
        check("mem_wdata", mem_wdata_o, ewd);

        if (rst_i) begin
            if (e0 || e1) begin
                if (ew) begin
                    for (int b = 0; b < 4; b++)
                        if (ebe[b]) shd_mem[ea[7:2]][8*b +: 8] = ewd[8*b +: 8];
                end else begin
                    exp_q.push_back({e1, shd_mem[ea[7:2]]});
                end
                mdl_last = e1;
            end
            if (e1 || !m1_req_i) mdl_run = 0;
            else if (e0 && mdl_run < 255) mdl_run++;
        end
        @(negedge clk_i);
    endtask

    task automatic set_idle();
        m0_req_i = 1'b0; m0_we_i = 1'b0; m0_be_i = 4'd0; m0_addr_i = 32'd0; m0_wdata_i = 32'd0;
        m1_req_i = 1'b0; m1_we_i = 1'b0; m1_be_i = 4'd0; m1_addr_i = 32'd0; m1_wdata_i = 32'd0;
    endtask

    task automatic apply_reset();
        rst_i = 1'b0;
        exp_q.delete();
        exp_hold[0] = 32'd0;
        exp_hold[1] = 32'd0;
        mdl_last = 1'b1;
        mdl_run  = 0;
        m0_req_i = 1'b1;
        m1_req_i = 1'b1;
        mem_ready_i = 1'b1;
        step();
        step();
        rst_i = 1'b1;
        set_idle();
    endtask

    // driver tasks
    task automatic drive_p0(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        m0_req_i = 1'b1; m0_we_i = we; m0_be_i = be; m0_addr_i = a; m0_wdata_i = d;
    endtask

    task automatic drive_p1(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        m1_req_i = 1'b1; m1_we_i = we; m1_be_i = be; m1_addr_i = a; m1_wdata_i = d;
    endtask

    logic [7:0] pat;
    logic [7:0] exp_pat;
    logic       h0, h1;

    initial begin
        for (int i = 0; i < 64; i++) shd_mem[i] = init_word(i);
        rst_i = 1'b0;
        mem_ready_i = 1'b1;
        set_idle();
        @(negedge clk_i);
        apply_reset();

        // port 0 alone: write then read back
        drive_p0(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        step();
        check("t1_wr_grant", 32'(obs_g0), 32'd1);
        drive_p0(1'b0, 4'h0, 32'h10, 32'd0);
        step();
        check("t1_rd_grant", 32'(obs_g0), 32'd1);
        set_idle();
        step();
        check("t1_rdata", m0_rdata_o, 32'hDEAD_BEEF);
        check("t1_m1_rdata", m1_rdata_o, 32'd0);

        // continuous contention from reset
        apply_reset();
        drive_p0(1'b0, 4'h0, 32'h0, 32'd0);
        drive_p1(1'b0, 4'h0, 32'h4, 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            pat[i] = obs_g1;
        end
`ifdef DMEM_ARB_RR_EN
        exp_pat = 8'b1010_1010;
`else
        exp_pat = 8'b1000_1000;
`endif
        check("grant_seq", 32'(pat), 32'(exp_pat));
        set_idle();
        step();

        // port 1 read data held while port 0 works
        drive_p1(1'b1, 4'hF, 32'h8, 32'h1234_5678);
        step();
        drive_p1(1'b0, 4'h0, 32'h8, 32'd0);
        step();
        m1_req_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_p0(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     32'($urandom_range(0, 7)) << 2, $urandom);
            step();
        end
        check("t4_hold", m1_rdata_o, 32'h1234_5678);

        // memory not ready
        drive_p0(1'b0, 4'h0, 32'h20, 32'd0);
        drive_p1(1'b0, 4'h0, 32'h24, 32'd0);
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_stall", 32'(obs_g0 | obs_g1), 32'd0);
        end
        mem_ready_i = 1'b1;
        step();
        check("t5_resume", 32'(obs_g0 | obs_g1), 32'd1);
        set_idle();
        step();

        // reset right after a granted read
        drive_p0(1'b0, 4'h0, 32'h10, 32'd0);
        step();
        apply_reset();
        drive_p0(1'b0, 4'h0, 32'h0, 32'd0);
        drive_p1(1'b0, 4'h0, 32'h4, 32'd0);
        step();
        check("t6_first_p0", 32'(obs_g0), 32'd1);
        set_idle();
        step();

        // randomized traffic with request hold until ready
        h0 = 1'b0;
        h1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!h0) begin
                m0_req_i = ($urandom_range(0, 9) < 7);
                if (m0_req_i) begin
                    drive_p0(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                             32'($urandom_range(0, 63)) << 2, $urandom);
                    h0 = 1'b1;
                end
            end
            if (!h1) begin
                m1_req_i = ($urandom_range(0, 9) < 7);
                if (m1_req_i) begin
                    drive_p1(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                             32'($urandom_range(0, 63)) << 2, $urandom);
                    h1 = 1'b1;
                end
            end
            mem_ready_i = ($urandom_range(0, 9) != 0);
            step();
            if (obs_g0) begin h0 = 1'b0; m0_req_i = 1'b0; end
            if (obs_g1) begin h1 = 1'b0; m1_req_i = 1'b0; end
        end
        set_idle();
        mem_ready_i = 1'b1;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
